// File: rtl/video_fetch_fta256.sv
// Scanline fetcher: issues LINE_WORDS 256-bit reads per fetch pulse with at
// most MAX_OUT reads in flight, and writes the returned words into a line
// buffer at the word index carried in the transaction id.
module video_fetch_fta256 #(
    parameter int          LINE_WORDS = 25,
    parameter int          MAX_OUT    = 8,
    parameter logic [31:0] STRIDE     = 32'd800
) (
    input  logic         rst,
    input  logic         clk,
    input  logic         vSync,
    input  logic         fetch,
    input  logic [31:0]  base_adr,
    output logic         req_cyc,
    output logic [31:0]  req_padr,
    output logic [7:0]   req_tid,
    input  logic         resp_stall,
    input  logic         resp_ack,
    input  logic [7:0]   resp_tid,
    input  logic [255:0] resp_dat,
    output logic         lb_we,
    output logic [5:0]   lb_wadr,
    output logic [255:0] lb_wdat,
    output logic         line_done,
    output logic         err_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [5:0] LAST_IDX  = 6'(LINE_WORDS - 1);
    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    logic [1:0]   state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [3:0]   out_q, out_d;
    logic [31:0]  line_adr_q, line_adr_d;
    logic         vsync_q;
    logic         lb_we_q, lb_we_d;
    logic [5:0]   lb_wadr_q, lb_wadr_d;
    logic [255:0] lb_wdat_q, lb_wdat_d;
    logic         line_done_q, line_done_d;
    logic         err_overrun_q, err_overrun_d;

    logic vsync_rise;
    logic ack_ok;
    logic issue_ok;
    logic accept;
    logic drain_done;

    // Only word index bits of the returning id are meaningful.
    logic unused_tid_hi;
    assign unused_tid_hi = ^resp_tid[7:6];

    // Handshake qualifiers; an ack with nothing in flight is stray and ignored.
    always_comb begin
        vsync_rise = vSync & ~vsync_q;
        ack_ok     = resp_ack && (out_q != 4'd0);
        issue_ok   = (state_q == S_ISSUE) && (out_q < MAX_OUT_C);
        accept     = issue_ok && !resp_stall;
        drain_done = (state_q == S_DRAIN) && (out_q == 4'd0);
    end

    // Line FSM and word index; DRAIN is entered only on acceptance of the last index.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (fetch) begin
                    state_d = S_ISSUE;
                    idx_d   = 6'd0;
                end
            end
            S_ISSUE: begin
                if (accept) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_q == 4'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding-read counter; simultaneous accept and ack cancel out.
    always_comb begin
        out_d = out_q;
        if (accept && !ack_ok) begin
            out_d = out_q + 4'd1;
        end else if (!accept && ack_ok) begin
            out_d = out_q - 4'd1;
        end
    end

    // Line start address: vSync reload wins over end-of-line advance.
    always_comb begin
        line_adr_d = line_adr_q;
        if (vsync_rise) begin
            line_adr_d = base_adr;
        end else if (drain_done) begin
            line_adr_d = line_adr_q + STRIDE;
        end
    end

    // Registered line buffer write and status pulses.
    always_comb begin
        lb_we_d       = ack_ok;
        lb_wadr_d     = lb_wadr_q;
        lb_wdat_d     = lb_wdat_q;
        if (ack_ok) begin
            lb_wadr_d = resp_tid[5:0];
            lb_wdat_d = resp_dat;
        end
        line_done_d   = drain_done;
        err_overrun_d = fetch && (state_q != S_IDLE);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 6'd0;
            out_q         <= 4'd0;
            line_adr_q    <= 32'd0;
            vsync_q       <= 1'b0;
            lb_we_q       <= 1'b0;
            lb_wadr_q     <= 6'd0;
            lb_wdat_q     <= 256'd0;
            line_done_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            out_q         <= out_d;
            line_adr_q    <= line_adr_d;
            vsync_q       <= vSync;
            lb_we_q       <= lb_we_d;
            lb_wadr_q     <= lb_wadr_d;
            lb_wdat_q     <= lb_wdat_d;
            line_done_q   <= line_done_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Request outputs come straight from reset-cleared state, so they drop
    // to zero as soon as rst asserts; under stall idx_q holds them steady.
    assign req_cyc     = issue_ok;
    assign req_padr    = line_adr_q + {21'd0, idx_q, 5'd0};
    assign req_tid     = {2'b00, idx_q};
    assign lb_we       = lb_we_q;
    assign lb_wadr     = lb_wadr_q;
    assign lb_wdat     = lb_wdat_q;
    assign line_done   = line_done_q;
    assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_video_fetch_fta256.sv
// Directed bench for video_fetch_fta256: in-order, stalled, held and
// LIFO-ordered responders, vSync reload, overrun and mid-line reset.
module tb_video_fetch_fta256;

    localparam int LW = 25;
    localparam int MO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vSync = 1'b0;
    logic         fetch = 1'b0;
    logic [31:0]  base_adr = 32'd0;
    logic         req_cyc;
    logic [31:0]  req_padr;
    logic [7:0]   req_tid;
    logic         resp_stall = 1'b0;
    logic         resp_ack = 1'b0;
    logic [7:0]   resp_tid = 8'd0;
    logic [255:0] resp_dat = 256'd0;
    logic         lb_we;
    logic [5:0]   lb_wadr;
    logic [255:0] lb_wdat;
    logic         line_done;
    logic         err_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    logic [63:0] wr_mask = 64'd0;

    video_fetch_fta256 #(.LINE_WORDS(LW), .MAX_OUT(MO), .STRIDE(32'd800)) dut (
        .rst(rst), .clk(clk), .vSync(vSync), .fetch(fetch), .base_adr(base_adr),
        .req_cyc(req_cyc), .req_padr(req_padr), .req_tid(req_tid),
        .resp_stall(resp_stall), .resp_ack(resp_ack), .resp_tid(resp_tid),
        .resp_dat(resp_dat), .lb_we(lb_we), .lb_wadr(lb_wadr), .lb_wdat(lb_wdat),
        .line_done(line_done), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mkdat(input logic [5:0] t);
        return {8{24'hC0FFEE, 2'b00, t}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line buffer / pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (lb_we === 1'b1) begin
            wr_cnt++;
            wr_mask[lb_wadr] = 1'b1;
            chk("lb_wdat", lb_wdat, mkdat(lb_wadr));
        end
        if (line_done === 1'b1) done_cnt++;
        if (err_overrun === 1'b1) ovr_cnt++;
    end

    // Responder acks each accepted word one cycle later, optional stall window,
    // optional fetch pulse on the first DRAIN cycle.
    task automatic run_line(input logic [31:0] start, input int stall_at,
                            input int stall_len, input bit ovr);
        int k = 0;
        int st = 0;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        int o0 = ovr_cnt;
        bit pv = 0;
        bit ackd = 0;
        bit fired = 0;
        bit done = 0;
        logic [5:0] pt = 6'd0;
        logic [5:0] apt = 6'd0;
        wr_mask = 64'd0;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (ackd) begin
                chk("lb_we", lb_we, 1'b1);
                chk("lb_wadr", lb_wadr, apt);
            end
            resp_ack = pv;
            resp_tid = {2'b00, pt};
            resp_dat = mkdat(pt);
            ackd = pv;
            apt = pt;
            resp_stall = (k == stall_at) && (st < stall_len);
            fetch = ovr && (k == LW) && !fired;
            if (fetch) fired = 1;
            pv = 0;
            if (req_cyc) begin
                if (k >= LW) begin
                    chk("extra_req", req_cyc, 1'b0);
                end else begin
                    chk("req_padr", req_padr, start + 32'(k * 32));
                    chk("req_tid", req_tid, 8'(k));
                    if (!resp_stall) begin
                        pv = 1;
                        pt = 6'(k);
                        k++;
                    end else begin
                        st++;
                    end
                end
            end
            step();
            if (done_cnt != d0) done = 1;
        end
        resp_ack = 1'b0;
        resp_stall = 1'b0;
        fetch = 1'b0;
        chk("line_done_seen", done, 1'b1);
        chk("words_issued", k, LW);
        chk("stall_cycles", st, stall_len);
        chk("writes", wr_cnt - w0, LW);
        chk("write_mask", wr_mask, (64'd1 << LW) - 64'd1);
        chk("line_done_count", done_cnt - d0, 1);
        chk("overrun_count", ovr_cnt - o0, ovr ? 1 : 0);
    endtask

    // Responder withholds acks until the window fills, then returns newest first.
    task automatic run_lifo(input logic [31:0] start);
        int k = 0;
        int w0 = wr_cnt;
        int d0 = done_cnt;
        bit ackd = 0;
        bit done = 0;
        logic [5:0] apt = 6'd0;
        logic [5:0] stk[$];
        wr_mask = 64'd0;
        resp_ack = 1'b0;
        resp_stall = 1'b0;
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (req_cyc) begin
                chk("hold_padr", req_padr, start + 32'(k * 32));
                chk("hold_tid", req_tid, 8'(k));
                stk.push_back(6'(k));
                k++;
            end
            step();
        end
        chk("hold_accepts", k, MO);
        chk("hold_req_cyc", req_cyc, 1'b0);
        apt = stk.pop_back();
        resp_ack = 1'b1;
        resp_tid = {2'b00, apt};
        resp_dat = mkdat(apt);
        step();
        resp_ack = 1'b0;
        chk("release_lb_we", lb_we, 1'b1);
        chk("release_lb_wadr", lb_wadr, apt);
        chk("release_req_cyc", req_cyc, 1'b1);
        chk("release_tid", req_tid, 8'(k));
        stk.push_back(6'(k));
        k++;
        step();
        chk("refull_req_cyc", req_cyc, 1'b0);
        for (int c = 0; c < 400 && !done; c++) begin
            if (ackd) begin
                chk("lifo_lb_we", lb_we, 1'b1);
                chk("lifo_lb_wadr", lb_wadr, apt);
            end
            ackd = 0;
            resp_ack = 1'b0;
            if (req_cyc) begin
                if (k >= LW) begin
                    chk("lifo_extra_req", req_cyc, 1'b0);
                end else begin
                    chk("lifo_padr", req_padr, start + 32'(k * 32));
                    chk("lifo_tid", req_tid, 8'(k));
                    stk.push_back(6'(k));
                    k++;
                end
            end else if (stk.size() > 0) begin
                apt = stk.pop_back();
                resp_ack = 1'b1;
                resp_tid = {2'b00, apt};
                resp_dat = mkdat(apt);
                ackd = 1;
            end
            step();
            if (done_cnt != d0) done = 1;
        end
        resp_ack = 1'b0;
        chk("lifo_done_seen", done, 1'b1);
        chk("lifo_words", k, LW);
        chk("lifo_writes", wr_cnt - w0, LW);
        chk("lifo_mask", wr_mask, (64'd1 << LW) - 64'd1);
        chk("lifo_done_count", done_cnt - d0, 1);
    endtask

    task automatic vsync_pulse();
        vSync = 1'b1;
        step();
        vSync = 1'b0;
        step();
    endtask

    initial begin
        int k;
        // Reset state
        #12;
        chk("rst_req_cyc", req_cyc, 1'b0);
        chk("rst_req_padr", req_padr, 32'd0);
        chk("rst_req_tid", req_tid, 8'd0);
        chk("rst_lb_we", lb_we, 1'b0);
        chk("rst_lb_wdat", lb_wdat, 256'd0);
        chk("rst_line_done", line_done, 1'b0);
        chk("rst_err_overrun", err_overrun, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("idle_req_cyc", req_cyc, 1'b0);

        // Line 1 from base, line 2 one stride on with a 5-cycle stall
        base_adr = 32'h1000;
        vsync_pulse();
        run_line(32'h1000, -1, 0, 1'b0);
        run_line(32'h1320, 7, 5, 1'b0);

        // vSync returns to base; overrun fetch during DRAIN
        vsync_pulse();
        run_line(32'h1000, -1, 0, 1'b1);

        // Held acks, then out-of-order returns
        run_lifo(32'h1320);

        // Reset in the middle of ISSUE with a write in flight
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        step();
        resp_ack = 1'b1;
        resp_tid = 8'd0;
        resp_dat = mkdat(6'd0);
        step();
        resp_ack = 1'b0;
        chk("pre_rst_lb_we", lb_we, 1'b1);
        chk("pre_rst_req_cyc", req_cyc, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_cyc", req_cyc, 1'b0);
        chk("mid_rst_req_padr", req_padr, 32'd0);
        chk("mid_rst_req_tid", req_tid, 8'd0);
        chk("mid_rst_lb_we", lb_we, 1'b0);
        chk("mid_rst_lb_wadr", lb_wadr, 6'd0);
        chk("mid_rst_lb_wdat", lb_wdat, 256'd0);
        chk("mid_rst_line_done", line_done, 1'b0);
        chk("mid_rst_err_overrun", err_overrun, 1'b0);
        step();
        rst = 1'b0;

        // Stray ack after reset is dropped and does not underflow the counter
        resp_ack = 1'b1;
        resp_tid = 8'd1;
        resp_dat = mkdat(6'd1);
        step();
        resp_ack = 1'b0;
        chk("stray_lb_we", lb_we, 1'b0);
        chk("stray_req_cyc", req_cyc, 1'b0);

        // No vSync since reset: line address still 0
        fetch = 1'b1;
        step();
        fetch = 1'b0;
        chk("novsync_padr", req_padr, 32'd0);
        chk("novsync_tid", req_tid, 8'd0);
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_cyc) k++;
            step();
        end
        chk("post_rst_window", k, MO);
        chk("post_rst_req_cyc", req_cyc, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
